// File: rtl/ser_core_gen.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : ser_core_gen
//  Purpose  : Full-duplex asynchronous serial transceiver. TX holding
//             register plus shifter, RX with 2-flop synchronizer and
//             oversampled centre alignment, first-word-fall-through RX FIFO,
//             sticky framing/parity/overrun flags, optional two-tone output.
//  Options  : SERGEN_TWO_TONE_EN - when defined, cfgTwoTone=1 makes SOD
//             carry toneA (mark) / toneB (space) instead of the raw bit.
//  Ports    : clk, nInit (async active-low reset)
//             txTick/rxTick     bit-rate and oversample tick pulses
//             cfgParity/Stop2/TwoTone, toneA/toneB  configuration and tones
//             txWr/txData/txFull/txBusy/txDone      transmit side
//             SID/SOD                               serial line in/out
//             rxRd/rxData/rxEmpty/rxCount/rxDone    receive FIFO side
//             framerr/parerr/overrun/clrErr         sticky error flags
//  Revision : 1.0  initial release
// ============================================================================
module ser_core_gen #(
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int OVS        = 16
) (
    input  logic                         clk,
    input  logic                         nInit,
    input  logic                         txTick,
    input  logic                         rxTick,
    input  logic [1:0]                   cfgParity,
    input  logic                         cfgStop2,
    input  logic                         cfgTwoTone,
    input  logic                         toneA,
    input  logic                         toneB,
    input  logic                         txWr,
    input  logic [DATA_BITS-1:0]         txData,
    output logic                         txFull,
    output logic                         txBusy,
    output logic                         txDone,
    input  logic                         SID,
    output logic                         SOD,
    input  logic                         rxRd,
    output logic [DATA_BITS-1:0]         rxData,
    output logic                         rxEmpty,
    output logic [$clog2(FIFO_DEPTH):0]  rxCount,
    output logic                         rxDone,
    output logic                         framerr,
    output logic                         parerr,
    output logic                         overrun,
    input  logic                         clrErr
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int OS_W  = $clog2(OVS);
    localparam int BC_W  = $clog2(DATA_BITS);

    localparam logic [OS_W-1:0]  OS_HALF = OS_W'(OVS / 2 - 1);
    localparam logic [OS_W-1:0]  OS_LAST = OS_W'(OVS - 1);
    localparam logic [BC_W-1:0]  BC_LAST = BC_W'(DATA_BITS - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

    // Parity bit for a data word: 01 even, 10 odd, 11 mark.
    function automatic logic par_calc(input logic [DATA_BITS-1:0] d,
                                      input logic [1:0]           mode);
        case (mode)
            2'b01:   par_calc = ^d;
            2'b10:   par_calc = ~^d;
            default: par_calc = 1'b1;
        endcase
    endfunction

    // ------------------------------------------------------------------
    // Transmitter
    // ------------------------------------------------------------------
    typedef enum logic [2:0] {
        TX_IDLE   = 3'd0,
        TX_START  = 3'd1,
        TX_DATA   = 3'd2,
        TX_PARITY = 3'd3,
        TX_STOP1  = 3'd4,
        TX_STOP2  = 3'd5
    } tx_state_t;

    tx_state_t            tx_state;
    logic [DATA_BITS-1:0] tx_hold;
    logic [DATA_BITS-1:0] tx_shift;
    logic [BC_W-1:0]      tx_cnt;
    logic                 tx_bit;      // line level of the current bit
    logic                 tx_par_bit;
    logic                 tx_par_en;
    logic                 tx_stop2;

    always_ff @(posedge clk or negedge nInit) begin
        if (!nInit) begin
            tx_state   <= TX_IDLE;
            tx_hold    <= '0;
            tx_shift   <= '0;
            tx_cnt     <= '0;
            tx_bit     <= 1'b1;
            tx_par_bit <= 1'b0;
            tx_par_en  <= 1'b0;
            tx_stop2   <= 1'b0;
            txFull     <= 1'b0;
            txBusy     <= 1'b0;
            txDone     <= 1'b0;
        end else begin
            txDone <= 1'b0;
            if (txWr && !txFull) begin
                tx_hold <= txData;
                txFull  <= 1'b1;
            end
            if (txTick) begin
                case (tx_state)
                    TX_IDLE: begin
                        if (txFull) begin
                            // Frame configuration is frozen here so a
                            // mid-frame register write cannot corrupt it.
                            tx_shift   <= tx_hold;
                            tx_par_bit <= par_calc(tx_hold, cfgParity);
                            tx_par_en  <= (cfgParity != 2'b00);
                            tx_stop2   <= cfgStop2;
                            txFull     <= 1'b0;
                            txBusy     <= 1'b1;
                            tx_bit     <= 1'b0;
                            tx_state   <= TX_START;
                        end
                    end
                    TX_START: begin
                        tx_bit   <= tx_shift[0];
                        tx_shift <= tx_shift >> 1;
                        tx_cnt   <= '0;
                        tx_state <= TX_DATA;
                    end
                    TX_DATA: begin
                        if (tx_cnt == BC_LAST) begin
                            if (tx_par_en) begin
                                tx_bit   <= tx_par_bit;
                                tx_state <= TX_PARITY;
                            end else begin
                                tx_bit   <= 1'b1;
                                tx_state <= TX_STOP1;
                            end
                        end else begin
                            tx_cnt   <= tx_cnt + 1'b1;
                            tx_bit   <= tx_shift[0];
                            tx_shift <= tx_shift >> 1;
                        end
                    end
                    TX_PARITY: begin
                        tx_bit   <= 1'b1;
                        tx_state <= TX_STOP1;
                    end
                    TX_STOP1: begin
                        if (tx_stop2) begin
                            tx_state <= TX_STOP2;
                        end else begin
                            txBusy   <= 1'b0;
                            txDone   <= 1'b1;
                            tx_state <= TX_IDLE;
                        end
                    end
                    TX_STOP2: begin
                        txBusy   <= 1'b0;
                        txDone   <= 1'b1;
                        tx_state <= TX_IDLE;
                    end
                    default: tx_state <= TX_IDLE;
                endcase
            end
        end
    end

    // Output register: the line is always one flop after tx_bit so that
    // the tone-modulated and raw paths share the same latency.
    always_ff @(posedge clk or negedge nInit) begin
        if (!nInit) begin
            SOD <= 1'b1;
        end else begin
`ifdef SERGEN_TWO_TONE_EN
            SOD <= cfgTwoTone ? (tx_bit ? toneA : toneB) : tx_bit;
`else
            SOD <= tx_bit;
`endif
        end
    end

`ifndef SERGEN_TWO_TONE_EN
    logic unused_tone;
    assign unused_tone = &{1'b0, cfgTwoTone, toneA, toneB};
`endif

    // ------------------------------------------------------------------
    // Receiver
    // ------------------------------------------------------------------
    typedef enum logic [2:0] {
        RX_IDLE   = 3'd0,
        RX_START  = 3'd1,
        RX_DATA   = 3'd2,
        RX_PARITY = 3'd3,
        RX_STOP   = 3'd4
    } rx_state_t;

    rx_state_t            rx_state;
    logic                 rx_s1;
    logic                 rx_s2;
    logic [OS_W-1:0]      rx_os;
    logic [BC_W-1:0]      rx_cnt;
    logic [DATA_BITS-1:0] rx_shift;
    logic [1:0]           rx_mode;
    logic                 rx_par_bit;
    logic                 push_req;
    logic [DATA_BITS-1:0] push_word;

    always_ff @(posedge clk or negedge nInit) begin
        if (!nInit) begin
            rx_s1 <= 1'b1;
            rx_s2 <= 1'b1;
        end else begin
            rx_s1 <= SID;
            rx_s2 <= rx_s1;
        end
    end

    always_ff @(posedge clk or negedge nInit) begin
        if (!nInit) begin
            rx_state   <= RX_IDLE;
            rx_os      <= '0;
            rx_cnt     <= '0;
            rx_shift   <= '0;
            rx_mode    <= 2'b00;
            rx_par_bit <= 1'b0;
            push_req   <= 1'b0;
            push_word  <= '0;
            rxDone     <= 1'b0;
            framerr    <= 1'b0;
            parerr     <= 1'b0;
        end else begin
            rxDone   <= 1'b0;
            push_req <= 1'b0;
            // Clear first; a set later in this block overrides it.
            if (clrErr) begin
                framerr <= 1'b0;
                parerr  <= 1'b0;
            end
            if (rxTick) begin
                case (rx_state)
                    RX_IDLE: begin
                        if (!rx_s2) begin
                            rx_os    <= '0;
                            rx_mode  <= cfgParity;
                            rx_state <= RX_START;
                        end
                    end
                    RX_START: begin
                        // Half a bit in: still low means a real start bit,
                        // and restarting the count centres later samples.
                        if (rx_os == OS_HALF) begin
                            rx_os <= '0;
                            if (rx_s2) begin
                                rx_state <= RX_IDLE;
                            end else begin
                                rx_cnt   <= '0;
                                rx_state <= RX_DATA;
                            end
                        end else begin
                            rx_os <= rx_os + 1'b1;
                        end
                    end
                    RX_DATA: begin
                        if (rx_os == OS_LAST) begin
                            rx_os    <= '0;
                            rx_shift <= {rx_s2, rx_shift[DATA_BITS-1:1]};
                            if (rx_cnt == BC_LAST) begin
                                rx_state <= (rx_mode != 2'b00) ? RX_PARITY : RX_STOP;
                            end else begin
                                rx_cnt <= rx_cnt + 1'b1;
                            end
                        end else begin
                            rx_os <= rx_os + 1'b1;
                        end
                    end
                    RX_PARITY: begin
                        if (rx_os == OS_LAST) begin
                            rx_os      <= '0;
                            rx_par_bit <= rx_s2;
                            rx_state   <= RX_STOP;
                        end else begin
                            rx_os <= rx_os + 1'b1;
                        end
                    end
                    RX_STOP: begin
                        if (rx_os == OS_LAST) begin
                            rx_os <= '0;
                            if ((rx_mode != 2'b00) &&
                                (rx_par_bit != par_calc(rx_shift, rx_mode))) begin
                                parerr <= 1'b1;
                            end
                            if (!rx_s2) begin
                                framerr <= 1'b1;
                            end
                            push_req  <= 1'b1;
                            push_word <= rx_shift;
                            rxDone    <= 1'b1;
                            rx_state  <= RX_IDLE;
                        end else begin
                            rx_os <= rx_os + 1'b1;
                        end
                    end
                    default: rx_state <= RX_IDLE;
                endcase
            end
        end
    end

    // ------------------------------------------------------------------
    // Receive FIFO (first-word-fall-through)
    // ------------------------------------------------------------------
    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic                 fifo_full;
    logic                 do_push;
    logic                 do_pop;

    assign rxEmpty   = (rxCount == '0);
    assign fifo_full = (rxCount == CNT_FULL);
    assign do_pop    = rxRd && !rxEmpty;
    // When full, a simultaneous pop frees the slot the push needs.
    assign do_push   = push_req && (!fifo_full || do_pop);
    assign rxData    = rxEmpty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_word;
        end
    end

    always_ff @(posedge clk or negedge nInit) begin
        if (!nInit) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            rxCount <= '0;
            overrun <= 1'b0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   rxCount <= rxCount + 1'b1;
                2'b01:   rxCount <= rxCount - 1'b1;
                default: rxCount <= rxCount;
            endcase
            if (clrErr) begin
                overrun <= 1'b0;
            end
            if (push_req && !do_push) begin
                overrun <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ser_core_gen.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_ser_core_gen
//  Purpose  : Self-checking bench for ser_core_gen. Expected line bits and
//             received words are queued when stimulus is applied and popped
//             when the design produces them.
//  Revision : 1.0  initial release
// ============================================================================
module tb_ser_core_gen;

    localparam int DATA_BITS  = 8;
    localparam int FIFO_DEPTH = 4;
    localparam int OVS        = 16;
    localparam int CW         = $clog2(FIFO_DEPTH) + 1;

    logic                 clk = 1'b0;
    logic                 nInit = 1'b0;
    logic                 tx_man = 1'b0;
    logic                 tx_auto = 1'b0;
    logic                 tx_auto_en = 1'b0;
    logic                 rx_en = 1'b0;
    logic                 loop_en = 1'b0;
    logic                 sid_drv = 1'b1;
    logic                 txTick;
    logic                 rxTick;
    logic [1:0]           cfgParity = 2'b00;
    logic                 cfgStop2 = 1'b0;
    logic                 cfgTwoTone = 1'b0;
    logic                 toneA = 1'b0;
    logic                 toneB = 1'b0;
    logic                 txWr = 1'b0;
    logic [DATA_BITS-1:0] txData = '0;
    logic                 txFull, txBusy, txDone;
    logic                 SID, SOD;
    logic                 rxRd = 1'b0;
    logic [DATA_BITS-1:0] rxData;
    logic                 rxEmpty;
    logic [CW-1:0]        rxCount;
    logic                 rxDone;
    logic                 framerr, parerr, overrun;
    logic                 clrErr = 1'b0;

    int vectors = 0;
    int errors  = 0;
    int tx_done_cnt = 0;
    int rx_done_cnt = 0;

    logic                 tx_q[$];
    logic [DATA_BITS-1:0] rx_q[$];

    assign txTick = tx_man | tx_auto;
    assign rxTick = rx_en;               // every cycle: back-to-back ticks
    assign SID    = loop_en ? SOD : sid_drv;

    always #5 clk = ~clk;

    ser_core_gen #(.DATA_BITS(DATA_BITS), .FIFO_DEPTH(FIFO_DEPTH), .OVS(OVS)) dut (
        .clk(clk), .nInit(nInit), .txTick(txTick), .rxTick(rxTick),
        .cfgParity(cfgParity), .cfgStop2(cfgStop2), .cfgTwoTone(cfgTwoTone),
        .toneA(toneA), .toneB(toneB), .txWr(txWr), .txData(txData),
        .txFull(txFull), .txBusy(txBusy), .txDone(txDone), .SID(SID), .SOD(SOD),
        .rxRd(rxRd), .rxData(rxData), .rxEmpty(rxEmpty), .rxCount(rxCount),
        .rxDone(rxDone), .framerr(framerr), .parerr(parerr), .overrun(overrun),
        .clrErr(clrErr)
    );

    always @(posedge clk) begin
        if (txDone) tx_done_cnt <= tx_done_cnt + 1;
        if (rxDone) rx_done_cnt <= rx_done_cnt + 1;
    end

    // Free-running TX bit tick: one pulse every OVS cycles.
    initial begin : tick_gen
        int div;
        div = 0;
        forever begin
            @(negedge clk);
            if (tx_auto_en) begin
                div = (div + 1) % OVS;
                tx_auto = (div == 0);
            end else begin
                div = 0;
                tx_auto = 1'b0;
            end
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic pulse_tx_tick();
        @(negedge clk); tx_man = 1'b1;
        @(negedge clk); tx_man = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    // Bit-bangs one frame on SID, OVS cycles (= OVS rxTicks) per bit.
    task automatic send_sid_frame(input logic [7:0] d, input logic use_par,
                                  input logic par_bit, input logic stop_bit);
        sid_drv = 1'b0;
        repeat (OVS) @(negedge clk);
        for (int i = 0; i < DATA_BITS; i++) begin
            sid_drv = d[i];
            repeat (OVS) @(negedge clk);
        end
        if (use_par) begin
            sid_drv = par_bit;
            repeat (OVS) @(negedge clk);
        end
        sid_drv = stop_bit;
        repeat (OVS) @(negedge clk);
        sid_drv = 1'b1;
        repeat (2 * OVS) @(negedge clk);
    endtask

    task automatic test_reset();
        nInit = 1'b0;
        repeat (3) @(negedge clk);
        vectors++; if (SOD !== 1'b1) begin errors++; $display("FAIL reset_SOD: got %b want 1", SOD); end
        vectors++; if ({txFull, txBusy, txDone} !== 3'b000) begin errors++; $display("FAIL reset_tx: got %b want 000", {txFull, txBusy, txDone}); end
        vectors++; if ({rxDone, framerr, parerr, overrun} !== 4'b0000) begin errors++; $display("FAIL reset_rxflags: got %b want 0000", {rxDone, framerr, parerr, overrun}); end
        vectors++; if (rxEmpty !== 1'b1) begin errors++; $display("FAIL reset_rxEmpty: got %b want 1", rxEmpty); end
        vectors++; if (rxCount !== '0) begin errors++; $display("FAIL reset_rxCount: got %0d want 0", rxCount); end
        vectors++; if (rxData !== '0) begin errors++; $display("FAIL reset_rxData: got %h want 00", rxData); end
        nInit = 1'b1;
        rx_en = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_tx_frame();
        logic [7:0] d;
        logic       exp;
        int         done0;
        d = 8'hA5;
        cfgParity = 2'b01; cfgStop2 = 1'b1;
        tx_q.delete();
        tx_q.push_back(1'b0);
        for (int i = 0; i < 8; i++) tx_q.push_back(d[i]);
        tx_q.push_back(^d);
        tx_q.push_back(1'b1);
        tx_q.push_back(1'b1);
        done0 = tx_done_cnt;
        @(negedge clk); txWr = 1'b1; txData = d;
        @(negedge clk); txWr = 1'b0;
        vectors++; if (txFull !== 1'b1) begin errors++; $display("FAIL tx_full_set: got %b want 1", txFull); end
        // Ignored write while the holding register is occupied.
        txWr = 1'b1; txData = 8'h5A;
        @(negedge clk); txWr = 1'b0;
        for (int n = 0; n < 12; n++) begin
            pulse_tx_tick();
            exp = tx_q.pop_front();
            vectors++; if (SOD !== exp) begin errors++; $display("FAIL tx_bit%0d: got %b want %b", n, SOD, exp); end
            if (n == 0) begin
                vectors++; if ({txFull, txBusy} !== 2'b01) begin errors++; $display("FAIL tx_after_load: got full,busy=%b want 01", {txFull, txBusy}); end
            end
        end
        pulse_tx_tick();
        vectors++; if (tx_done_cnt - done0 !== 1) begin errors++; $display("FAIL tx_done_count: got %0d want 1", tx_done_cnt - done0); end
        vectors++; if ({txBusy, SOD} !== 2'b01) begin errors++; $display("FAIL tx_end_idle: got busy,SOD=%b want 01", {txBusy, SOD}); end
    endtask

    task automatic test_loopback();
        logic [7:0] words [3];
        logic [7:0] exp;
        int         done0;
        int         c;
        words[0] = 8'h3C; words[1] = 8'hFF; words[2] = 8'h00;
        cfgParity = 2'b10; cfgStop2 = 1'b0;
        loop_en = 1'b1; tx_auto_en = 1'b1;
        done0 = rx_done_cnt;
        for (int i = 0; i < 3; i++) begin
            c = 0;
            while (txFull && c < 2000) begin @(negedge clk); c++; end
            vectors++; if (txFull !== 1'b0) begin errors++; $display("FAIL loop_txfull_wait%0d: got %b want 0", i, txFull); end
            txWr = 1'b1; txData = words[i];
            rx_q.push_back(words[i]);
            @(negedge clk); txWr = 1'b0;
        end
        c = 0;
        while ((rx_done_cnt - done0) < 3 && c < 3000) begin @(negedge clk); c++; end
        repeat (3) @(negedge clk);
        vectors++; if (rxCount !== CW'(3)) begin errors++; $display("FAIL loop_rxCount: got %0d want 3", rxCount); end
        vectors++; if ({framerr, parerr, overrun} !== 3'b000) begin errors++; $display("FAIL loop_flags: got %b want 000", {framerr, parerr, overrun}); end
        while (rx_q.size() > 0) begin
            exp = rx_q.pop_front();
            vectors++; if (rxData !== exp) begin errors++; $display("FAIL loop_rxData: got %h want %h", rxData, exp); end
            rxRd = 1'b1; @(negedge clk); rxRd = 1'b0;
        end
        vectors++; if (rxEmpty !== 1'b1) begin errors++; $display("FAIL loop_empty: got %b want 1", rxEmpty); end
        c = 0;
        while (txBusy && c < 1000) begin @(negedge clk); c++; end
        tx_auto_en = 1'b0; loop_en = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_glitch();
        int done0;
        cfgParity = 2'b01;
        done0 = rx_done_cnt;
        sid_drv = 1'b0;
        repeat (3) @(negedge clk);
        sid_drv = 1'b1;
        repeat (40) @(negedge clk);
        vectors++; if (rx_done_cnt - done0 !== 0) begin errors++; $display("FAIL glitch_rxDone: got %0d want 0", rx_done_cnt - done0); end
        vectors++; if (rxCount !== '0) begin errors++; $display("FAIL glitch_rxCount: got %0d want 0", rxCount); end
        // A clean frame right after shows the receiver went back to idle.
        rx_q.push_back(8'h96);
        send_sid_frame(8'h96, 1'b1, 1'b0, 1'b1);
        vectors++; if (rx_done_cnt - done0 !== 1) begin errors++; $display("FAIL glitch_next_rxDone: got %0d want 1", rx_done_cnt - done0); end
        vectors++; if (rxData !== rx_q[0]) begin errors++; $display("FAIL glitch_next_data: got %h want %h", rxData, rx_q[0]); end
        vectors++; if ({framerr, parerr} !== 2'b00) begin errors++; $display("FAIL glitch_next_flags: got %b want 00", {framerr, parerr}); end
        void'(rx_q.pop_front());
        rxRd = 1'b1; @(negedge clk); rxRd = 1'b0;
    endtask

    task automatic test_errors();
        cfgParity = 2'b01;
        rx_q.push_back(8'h55);
        // 0x55 has even weight, so even parity is 0; send 1 and a low stop.
        send_sid_frame(8'h55, 1'b1, 1'b1, 1'b0);
        vectors++; if ({framerr, parerr} !== 2'b11) begin errors++; $display("FAIL err_flags_set: got %b want 11", {framerr, parerr}); end
        vectors++; if (rxCount !== CW'(1)) begin errors++; $display("FAIL err_pushed: got %0d want 1", rxCount); end
        vectors++; if (rxData !== rx_q[0]) begin errors++; $display("FAIL err_data: got %h want %h", rxData, rx_q[0]); end
        void'(rx_q.pop_front());
        clrErr = 1'b1; @(negedge clk); clrErr = 1'b0;
        vectors++; if ({framerr, parerr} !== 2'b00) begin errors++; $display("FAIL err_cleared: got %b want 00", {framerr, parerr}); end
        rxRd = 1'b1; @(negedge clk); rxRd = 1'b0;
    endtask

    task automatic test_overrun();
        logic [7:0] d;
        logic [7:0] exp;
        cfgParity = 2'b00;
        for (int i = 1; i <= 5; i++) begin
            d = 8'(i * 17);
            if (i <= FIFO_DEPTH) rx_q.push_back(d);
            send_sid_frame(d, 1'b0, 1'b0, 1'b1);
        end
        vectors++; if (rxCount !== CW'(FIFO_DEPTH)) begin errors++; $display("FAIL ovr_rxCount: got %0d want %0d", rxCount, FIFO_DEPTH); end
        vectors++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_flag: got %b want 1", overrun); end
        while (rx_q.size() > 0) begin
            exp = rx_q.pop_front();
            vectors++; if (rxData !== exp) begin errors++; $display("FAIL ovr_data: got %h want %h", rxData, exp); end
            rxRd = 1'b1; @(negedge clk); rxRd = 1'b0;
        end
        // Pop while empty is ignored.
        rxRd = 1'b1; @(negedge clk); rxRd = 1'b0;
        vectors++; if ({rxEmpty, rxCount} !== {1'b1, CW'(0)}) begin errors++; $display("FAIL ovr_empty: got empty=%b count=%0d want 1/0", rxEmpty, rxCount); end
        clrErr = 1'b1; @(negedge clk); clrErr = 1'b0;
        vectors++; if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_cleared: got %b want 0", overrun); end
    endtask

    task automatic test_two_tone();
        logic mark_lvl, space_lvl, exp;
        cfgParity = 2'b00; cfgStop2 = 1'b0;
        cfgTwoTone = 1'b1; toneA = 1'b0; toneB = 1'b1;
`ifdef SERGEN_TWO_TONE_EN
        mark_lvl = 1'b0; space_lvl = 1'b1;
`else
        mark_lvl = 1'b1; space_lvl = 1'b0;
`endif
        tx_q.delete();
        for (int i = 0; i < 9; i++) tx_q.push_back(space_lvl);  // start + 8 zero bits
        tx_q.push_back(mark_lvl);                               // stop bit
        repeat (2) @(negedge clk);
        vectors++; if (SOD !== mark_lvl) begin errors++; $display("FAIL tone_idle: got %b want %b", SOD, mark_lvl); end
        @(negedge clk); txWr = 1'b1; txData = 8'h00;
        @(negedge clk); txWr = 1'b0;
        for (int n = 0; n < 10; n++) begin
            pulse_tx_tick();
            exp = tx_q.pop_front();
            vectors++; if (SOD !== exp) begin errors++; $display("FAIL tone_bit%0d: got %b want %b", n, SOD, exp); end
        end
        pulse_tx_tick();
        cfgTwoTone = 1'b0;
    endtask

    initial begin
        test_reset();
        test_tx_frame();
        test_loopback();
        test_glitch();
        test_errors();
        test_overrun();
        test_two_tone();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ser_core_gen.md
# ser_core_gen

Parametrised successor to the POKEY serial core: a full-duplex asynchronous serial transceiver with configurable data width, runtime parity and stop-bit selection, and a receive FIFO. It also provides sticky error flags and optional two-tone (cassette FSK) output. It sits between the audio/timer block, which supplies the bit-rate tick pulses and tone sources, and the register file, which drives the write/read strobes and status. TX and RX run independently in one clock domain.

## Interface

- DATA_BITS, 8, data bits per frame, 5..9, LSB first
- FIFO_DEPTH, 4, RX FIFO entries, power of two, 2..16
- OVS, 16, RX oversample ratio (rxTick pulses per bit), even, 4..16
- clk  in  1  system clock, all state on rising edge
- nInit  in  1  asynchronous active-low reset
- txTick  in  1  one-cycle pulse per TX bit period
- rxTick  in  1  one-cycle pulse at OVS × RX bit rate
- cfgParity  in  2  00 none, 01 even, 10 odd, 11 mark (always 1)
- cfgStop2  in  1  1 = two TX stop bits (RX always checks one)
- cfgTwoTone  in  1  two-tone output select (see Configuration)
- toneA, toneB  in  1 each  tone square waves for mark/space
- txWr  in  1  load txData into holding register
- txData  in  DATA_BITS  byte to send
- txFull  out  1  holding register occupied
- txBusy  out  1  shifter active
- txDone  out  1  one-cycle pulse at end of last stop bit
- SID  in  1  serial data in, asynchronous, idle high
- SOD  out  1  serial data out, registered, idle high
- rxRd  in  1  pop RX FIFO head
- rxData  out  DATA_BITS  FIFO head, first-word-fall-through
- rxEmpty  out  1  FIFO empty
- rxCount  out  $clog2(FIFO_DEPTH)+1  entries held
- rxDone  out  1  one-cycle pulse per received frame
- framerr, parerr, overrun  out  1 each  sticky error flags
- clrErr  in  1  clears all three sticky flags

## Operation

- Reset (nInit low, async): SOD=1; txFull, txBusy, txDone, rxDone, flags=0; rxEmpty=1; rxCount=0; rxData=0; both FSMs IDLE.
- TX FSM: IDLE → START → DATA (DATA_BITS bits) → PARITY (skipped if cfgParity=00) → STOP1 → STOP2 (only if cfgStop2) → IDLE. Every transition happens on txTick only.
- TX IDLE with txFull on txTick: holding register moves to shifter; txFull clears; SOD=0.
- txWr while txFull=1 is ignored; holding register is unchanged.
- Parity: even = XOR of data bits; odd = inverted XOR; mark = 1. Parity config is latched at frame start.
- RX: SID passes through a 2-flop synchronizer. In IDLE, a synchronized 0 clears the oversample counter and enters START. At count OVS/2−1, if the line is still 0, centre-align; if 1, return to IDLE (glitch, nothing pushed).
- RX then samples every OVS rxTicks: DATA bits, PARITY (if enabled), STOP.
- At the STOP sample: parity mismatch sets parerr; STOP=0 sets framerr; word is pushed, even with errors; rxDone pulses. FSM returns to IDLE. A new start can be detected from the next rxTick.
- FIFO full at push: word is dropped, overrun set, existing contents are kept.
- Push and pop in the same cycle when full: both are accepted and rxCount is unchanged. When empty: only the push is accepted.
- rxRd while empty is ignored.
- clrErr and a set event in the same cycle: the set wins.

## Timing

- txWr → txFull high next cycle.
- First txTick after load → SOD low on that edge +1 cycle.
- Each bit lasts exactly one txTick interval. txDone pulses the cycle after the tick ending the final stop bit.
- RX push is registered on the rxTick at stop-bit centre. rxEmpty falls and rxCount increments one cycle later.
- rxRd → rxData shows the next entry the following cycle.
- Any txTick/rxTick spacing ≥1 cycle is legal; back-to-back ticks must work.

## Configuration

- SERGEN_TWO_TONE_EN defined, cfgTwoTone=1: SOD = registered (tx bit ? toneA : toneB). Idle and stop bits output toneA.
- SERGEN_TWO_TONE_EN defined, cfgTwoTone=0: SOD = raw tx bit.
- SERGEN_TWO_TONE_EN undefined: tone logic is absent. cfgTwoTone, toneA and toneB are ignored; SOD is always the raw tx bit.

## Test plan

- DATA_BITS=8, cfgParity=01, cfgStop2=1, txWr 0xA5 → SOD bit sequence 0,1,0,1,0,0,1,0,1,0,1,1 per txTick; txDone once; txFull low after the first tick.
- Loop SOD→SID with OVS=16, send 0x3C, 0xFF, 0x00 → rxData pops 0x3C, 0xFF, 0x00; rxCount peaks at 3; no flags.
- 3-rxTick low glitch on SID → no push, no rxDone, FSM back in IDLE.
- Frame with STOP=0 and wrong parity → framerr=1, parerr=1, word pushed; clrErr clears both.
- FIFO_DEPTH=4, receive 5 frames without rxRd → rxCount=4, overrun=1, head holds the first word.
- With SERGEN_TWO_TONE_EN defined, cfgTwoTone=1, send 0x00 → SOD follows toneB during data bits and toneA during stop bits.
